// File: rtl/md_pkg.sv
// md_pkg: op and state encodings shared by the multiply/divide unit and its arithmetic core.
package md_pkg;
  localparam logic [2:0] MD_MULT  = 3'd0;
  localparam logic [2:0] MD_MULTU = 3'd1;
  localparam logic [2:0] MD_DIV   = 3'd2;
  localparam logic [2:0] MD_DIVU  = 3'd3;
  localparam logic [2:0] MD_MTHI  = 3'd4;
  localparam logic [2:0] MD_MTLO  = 3'd5;
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;
  function automatic logic is_muldiv(input logic [2:0] op);
    return op <= MD_DIVU;
  endfunction
  function automatic logic is_div(input logic [2:0] op);
    return op == MD_DIV || op == MD_DIVU;
  endfunction
endpackage

// File: rtl/md_if.sv
// md_if: request/result bundle between a requester and the multiply/divide unit.
interface md_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  modport master(output start, op, A, B, input busy, hi, lo);
  modport slave(input start, op, A, B, output busy, hi, lo);
endinterface

// File: rtl/md_arith.sv
// md_arith: combinational product/quotient/remainder with divide-by-zero and signed-overflow results.
module md_arith
  import md_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  logic signed [2*WIDTH-1:0] sprod;
  logic [2*WIDTH-1:0] uprod;
  logic [WIDTH-1:0] sdiv, udiv, squo, srem, uquo, urem;
  logic bz, ovf;
  assign bz = b == '0;
  assign ovf = a == MIN_NEG && b == '1;
  // divisors are forced to 1 in the corner cases so the dividers never see /0 or MIN/-1
  assign sdiv = bz || ovf ? WIDTH'(1) : b;
  assign udiv = bz ? WIDTH'(1) : b;
  assign sprod = $signed({{WIDTH{a[WIDTH-1]}}, a}) * $signed({{WIDTH{b[WIDTH-1]}}, b});
  assign uprod = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
  assign squo = $signed(a) / $signed(sdiv);
  assign srem = $signed(a) % $signed(sdiv);
  assign uquo = a / udiv;
  assign urem = a % udiv;
  always_comb begin
    hi = op == MD_MULT ? sprod[2*WIDTH-1:WIDTH] : op == MD_MULTU ? uprod[2*WIDTH-1:WIDTH] :
         bz ? a : op == MD_DIVU ? urem : ovf ? '0 : srem;
    lo = op == MD_MULT ? sprod[WIDTH-1:0] : op == MD_MULTU ? uprod[WIDTH-1:0] :
         bz ? '1 : op == MD_DIVU ? uquo : ovf ? a : squo;
  end
endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit: HI/LO multiply/divide unit with fixed per-op latency; results land LAT cycles after acceptance.
module mult_div_unit
  import md_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10
) (
  input logic  clk,
  input logic  reset,
  md_if.slave  bus
);
  localparam int MAX_LAT = MULT_LAT > DIV_LAT ? MULT_LAT : DIV_LAT;
  localparam int CW = $clog2(MAX_LAT + 1);
  logic [0:0]       state;
  logic [CW-1:0]    cnt;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q, hi_q, lo_q, r_hi, r_lo;
  md_arith #(.WIDTH(WIDTH)) u_arith (.op(op_q), .a(a_q), .b(b_q), .hi(r_hi), .lo(r_lo));
  assign bus.busy = state == ST_BUSY;
  assign bus.hi = hi_q;
  assign bus.lo = lo_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt <= '0;
      op_q <= '0;
      a_q <= '0;
      b_q <= '0;
      hi_q <= '0;
      lo_q <= '0;
    end else if (state == ST_IDLE) begin
      if (bus.start && is_muldiv(bus.op)) begin
        state <= ST_BUSY;
        op_q <= bus.op;
        a_q <= bus.A;
        b_q <= bus.B;
        cnt <= is_div(bus.op) ? CW'(DIV_LAT) : CW'(MULT_LAT);
      end else if (bus.start && bus.op == MD_MTHI) hi_q <= bus.A;
      else if (bus.start && bus.op == MD_MTLO) lo_q <= bus.A;
    end else begin
      cnt <= cnt - CW'(1);
      if (cnt == CW'(1)) begin
        state <= ST_IDLE;
        hi_q <= r_hi;
        lo_q <= r_lo;
      end
    end
  end
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: random and directed stimulus on 32- and 16-bit units, scoreboarded against an arithmetic model.
module tb_mult_div_unit;
  typedef struct {
    int          due;
    logic [63:0] hi;
    logic [63:0] lo;
    logic        md;
    int          kind;
  } ent_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  ent_t sb[2][$];
  int   done_e[2];
  logic [63:0] mh[2], ml[2];
  logic [63:0] hi_s[2], lo_s[2];
  logic busy_s[2];

  md_if #(.WIDTH(32)) b32 ();
  md_if #(.WIDTH(16)) b16 ();
  mult_div_unit #(.WIDTH(32), .MULT_LAT(5), .DIV_LAT(10)) u32 (.clk(clk), .reset(rst), .bus(b32.slave));
  mult_div_unit #(.WIDTH(16), .MULT_LAT(3), .DIV_LAT(1)) u16 (.clk(clk), .reset(rst), .bus(b16.slave));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign hi_s[0] = {32'd0, b32.hi};
  assign lo_s[0] = {32'd0, b32.lo};
  assign busy_s[0] = b32.busy;
  assign hi_s[1] = {48'd0, b16.hi};
  assign lo_s[1] = {48'd0, b16.lo};
  assign busy_s[1] = b16.busy;

  function automatic int wid(input int d);
    return d == 0 ? 32 : 16;
  endfunction
  function automatic int lat_m(input int d);
    return d == 0 ? 5 : 3;
  endfunction
  function automatic int lat_d(input int d);
    return d == 0 ? 10 : 1;
  endfunction
  function automatic logic [63:0] mask(input int d);
    return (64'd1 << wid(d)) - 64'd1;
  endfunction

  // architectural result of one op, from plain integer arithmetic on the operands' values
  function automatic logic [127:0] model(input int w, input logic [2:0] o, input logic [63:0] a,
                                         input logic [63:0] b, input logic [63:0] h, input logic [63:0] l);
    logic [63:0] m = (64'd1 << w) - 64'd1;
    longint sa = longint'(a) - (a[w-1] ? (longint'(1) << w) : 64'sd0);
    longint sb = longint'(b) - (b[w-1] ? (longint'(1) << w) : 64'sd0);
    longint q, r;
    logic [63:0] p;
    case (o)
      3'd0: begin p = sa * sb; return {(p >> w) & m, p & m}; end
      3'd1: begin p = a * b; return {(p >> w) & m, p & m}; end
      3'd2: begin
        if (b == 64'd0) return {a, m};
        if (sa == -(longint'(1) << (w - 1)) && sb == -64'sd1) return {64'd0, a};
        q = sa / sb;
        r = sa - q * sb;
        return {64'(r) & m, 64'(q) & m};
      end
      3'd3: begin
        if (b == 64'd0) return {a, m};
        return {(a % b) & m, (a / b) & m};
      end
      3'd4: return {a, l};
      3'd5: return {h, a};
      default: return {h, l};
    endcase
  endfunction

  function automatic logic [63:0] rnd(input int d);
    int k = $urandom_range(0, 7);
    logic [63:0] m = mask(d);
    logic [63:0] v = {$urandom, $urandom};
    return k == 0 ? 64'd0 : k == 1 ? m : k == 2 ? (64'd1 << (wid(d) - 1)) : v & m;
  endfunction

  task automatic chk(input int d, input int k, input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL dut%0d op%0d %s: got %h, want %h (cycle %0d)", d, k, nm, act, exp, cyc);
    end
  endtask

  // drives one cycle of inputs; if the unit is idle in the model, the op is accepted at the next edge
  task automatic drv(input int d, input logic s, input logic [2:0] o, input logic [63:0] a, input logic [63:0] b);
    logic [63:0] m = mask(d);
    logic [127:0] r;
    ent_t e;
    if (d == 0) begin
      b32.start = s; b32.op = o; b32.A = a[31:0]; b32.B = b[31:0];
    end else begin
      b16.start = s; b16.op = o; b16.A = a[15:0]; b16.B = b[15:0];
    end
    if (s && cyc >= done_e[d]) begin
      r = model(wid(d), o, a & m, b & m, mh[d], ml[d]);
      mh[d] = r[127:64];
      ml[d] = r[63:0];
      e.md = o <= 3'd3;
      e.due = cyc + 1 + (o <= 3'd1 ? lat_m(d) : o <= 3'd3 ? lat_d(d) : 0);
      e.hi = mh[d];
      e.lo = ml[d];
      e.kind = int'(o);
      sb[d].push_back(e);
      if (e.md) done_e[d] = e.due;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_state(input int d, input int due);
    ent_t e;
    e.due = due; e.hi = mh[d]; e.lo = ml[d]; e.md = 1'b0; e.kind = 8;
    sb[d].push_back(e);
  endtask

  task automatic wait_idle(input int d);
    while (cyc < done_e[d]) begin
      drv(d, 1'b0, 3'd0, rnd(d), rnd(d));
      tick();
    end
  endtask

  task automatic release_reset();
    rst = 1'b0;
    for (int d = 0; d < 2; d++) begin
      mh[d] = 64'd0;
      ml[d] = 64'd0;
      done_e[d] = cyc;
      push_state(d, cyc);
    end
  endtask

  task automatic monitor(input int d);
    logic pb = 1'b0;
    logic [63:0] vh = 64'd0, vl = 64'd0;
    ent_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        pb = 1'b0; vh = 64'd0; vl = 64'd0;
        continue;
      end
      if ((pb && !busy_s[d]) || (sb[d].size() > 0 && sb[d][0].due == cyc)) begin
        if (sb[d].size() == 0) begin
          chk(d, 9, "unexpected_done", 64'(cyc), 64'd0);
        end else begin
          e = sb[d].pop_front();
          chk(d, e.kind, "cycle", 64'(cyc), 64'(e.due));
          chk(d, e.kind, "hi", hi_s[d], e.hi);
          chk(d, e.kind, "lo", lo_s[d], e.lo);
          chk(d, e.kind, "busy", 64'(busy_s[d]), 64'd0);
          if (e.md) chk(d, e.kind, "busy_before", 64'(pb), 64'd1);
          vh = e.hi;
          vl = e.lo;
        end
      end else if (busy_s[d]) begin
        chk(d, 10, "hold_hi", hi_s[d], vh);
        chk(d, 10, "hold_lo", lo_s[d], vl);
      end
      pb = busy_s[d];
    end
  endtask

  initial monitor(0);
  initial monitor(1);

  initial begin
    drv(0, 1'b0, 3'd0, 64'd0, 64'd0);
    drv(1, 1'b0, 3'd0, 64'd0, 64'd0);
    repeat (2) tick();
    release_reset();
    drv(0, 1'b1, 3'd0, 64'hFFFF_FFFD, 64'd7);
    tick();
    wait_idle(0);
    drv(0, 1'b1, 3'd1, 64'hFFFF_FFFF, 64'd2);
    tick();
    wait_idle(0);
    drv(0, 1'b1, 3'd2, 64'hFFFF_FFF9, 64'd2);
    tick();
    wait_idle(0);
    drv(0, 1'b1, 3'd3, 64'd7, 64'd0);
    tick();
    wait_idle(0);
    drv(0, 1'b1, 3'd2, 64'hFFFF_FFFB, 64'd0);
    tick();
    wait_idle(0);
    drv(0, 1'b1, 3'd2, 64'h8000_0000, 64'hFFFF_FFFF);
    tick();
    drv(0, 1'b1, 3'd4, 64'h1234, 64'd0);
    tick();
    wait_idle(0);
    drv(0, 1'b1, 3'd6, 64'hDEAD, 64'd1);
    tick();
    drv(0, 1'b1, 3'd7, 64'hBEEF, 64'd1);
    tick();
    drv(0, 1'b1, 3'd4, 64'hCAFE_0001, 64'd0);
    tick();
    drv(0, 1'b1, 3'd5, 64'h0BAD_F00D, 64'd0);
    tick();
    drv(0, 1'b1, 3'd3, 64'hFFFF_FFFF, 64'h10);
    tick();
    wait_idle(0);
    // abort a multiply two cycles into its latency
    drv(0, 1'b1, 3'd0, 64'h1234_5678, 64'h9ABC);
    tick();
    drv(0, 1'b0, 3'd0, 64'd0, 64'd0);
    tick();
    #2 rst = 1'b1;
    sb[0].delete();
    sb[1].delete();
    tick();
    release_reset();
    push_state(0, cyc + lat_m(0) + 2);
    repeat (lat_m(0) + 2) begin
      drv(0, 1'b0, 3'd0, rnd(0), rnd(0));
      tick();
    end
    drv(0, 1'b1, 3'd5, 64'h55, 64'd0);
    tick();
    drv(0, 1'b0, 3'd0, 64'd0, 64'd0);
    tick();
    for (int i = 0; i < 600; i++) begin
      drv(0, 1'b1, 3'($urandom_range(0, 7)), rnd(0), rnd(0));
      drv(1, 1'b1, 3'($urandom_range(0, 7)), rnd(1), rnd(1));
      tick();
    end
    drv(0, 1'b0, 3'd0, 64'd0, 64'd0);
    drv(1, 1'b0, 3'd0, 64'd0, 64'd0);
    for (int i = 0; i < 40 && (sb[0].size() > 0 || sb[1].size() > 0); i++) tick();
    checks++;
    if (sb[0].size() > 0 || sb[1].size() > 0) begin
      errors++;
      $display("FAIL drain: pending %0d/%0d results, want 0", sb[0].size(), sb[1].size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width in bits (≥8, even).
REQ-002 SHALL have parameter MULT_LAT, default 5, multiply latency in cycles (≥1).
REQ-003 SHALL have parameter DIV_LAT, default 10, divide latency in cycles (≥1).
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port start  input  1  request strobe, sampled at rising clk.
REQ-007 SHALL have port op  input  3  operation: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6-7 no-op.
REQ-008 SHALL have port A  input  WIDTH  first operand (multiplicand/dividend/MTHI-MTLO data).
REQ-009 SHALL have port B  input  WIDTH  second operand (multiplier/divisor).
REQ-010 SHALL have port busy  output  1  high while a multiply/divide is in flight.
REQ-011 SHALL have port hi  output  WIDTH  registered HI register.
REQ-012 SHALL have port lo  output  WIDTH  registered LO register.

Function
REQ-013 SHALL implement two states, IDLE (busy=0) and BUSY (busy=1).
REQ-014 SHALL accept start only in IDLE; start while BUSY is ignored, with no effect on hi, lo or timing.
REQ-015 On accepted op 0-3, SHALL latch A, B and op, load a down-counter with MULT_LAT (ops 0-1) or DIV_LAT (ops 2-3), and enter BUSY at that edge.
REQ-016 In BUSY, SHALL decrement the counter each cycle; on the edge where it reaches 0, SHALL write hi/lo and return to IDLE, so new hi/lo and busy=0 appear exactly LAT cycles after the accepting edge.
REQ-017 hi and lo SHALL hold their prior values throughout BUSY; no partial results visible.
REQ-018 MULT: {hi,lo} = signed(A)×signed(B), full 2·WIDTH product; MULTU: unsigned product.
REQ-019 DIV: lo = signed quotient truncated toward zero, hi = remainder with sign of dividend; DIVU: unsigned quotient/remainder.
REQ-020 Divide by zero (B=0): lo = all ones, hi = A, both signed and unsigned, same DIV_LAT latency.
REQ-021 Signed overflow (A = most-negative, B = -1, op DIV): lo = A, hi = 0.
REQ-022 MTHI/MTLO accepted in IDLE SHALL write A to hi/lo respectively at that edge; busy stays 0; the other register is unchanged.
REQ-023 ops 6-7 with start SHALL change nothing.
REQ-024 start may be accepted on the same cycle busy falls (first IDLE cycle after completion); back-to-back ops SHALL have no dead cycle beyond that.

Reset
REQ-025 reset high SHALL asynchronously force state IDLE, busy=0, hi=0, lo=0, counter=0, latched operands=0.
REQ-026 reset asserted mid-operation SHALL abort the operation; no result SHALL be written after reset release.
REQ-027 First start SHALL be accepted on the first rising clk after reset deassertion.

Structure
REQ-028 Op encodings (MD_MULT..MD_MTLO) and state encodings SHALL live in a shared package md_pkg, reused by the decoder.
REQ-029 Arithmetic (product, quotient, remainder, corner cases) SHALL be a combinational sub-module md_arith parametrised by WIDTH; mult_div_unit holds only state, counter and registers.
REQ-030 Results SHALL be computed from latched operands, so A/B changes during BUSY have no effect.

Verification
REQ-031 WIDTH=32, MULT_LAT=5: MULT A=-3, B=7 -> busy high 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFEB, busy=0.
REQ-032 MULTU A=0xFFFFFFFF, B=2 -> after 5 cycles hi=0x00000001, lo=0xFFFFFFFE.
REQ-033 DIV A=-7, B=2 -> after 10 cycles lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); DIVU A=7, B=0 -> lo=0xFFFFFFFF, hi=7.
REQ-034 DIV A=0x80000000, B=-1 -> lo=0x80000000, hi=0; MTHI A=0x1234 during BUSY -> ignored, hi unchanged after completion.
REQ-035 Start MULT, assert reset at cycle 2 of 5, release -> hi=lo=0, busy=0, no late write; then MTLO A=0x55 -> lo=0x55 next edge.
REQ-036 Random constrained ops at WIDTH=16 and WIDTH=32 against a reference model, start held high continuously -> every result matches and throughput equals one op per LAT+1 cycles.
